ans_encoder: RTL and testbench

//  Streaming rANS encoder; the inverse of ans_decoder. Accepts SYM_WIDTH-bit symbols, updates

---
 rtl/ans_encoder_if.sv | 29 ++
 rtl/ans_encoder.sv | 191 +++++++++++++++++++
 tb/tb_ans_encoder.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ans_encoder_if.sv
// Stream-in / stream-out / frequency-table bundle for the rANS encoder.
// master is the encoder's view; slave is the environment (source, sink, table).
interface ans_encoder_if #(
   parameter int SYM_WIDTH = 4,
   parameter int CNT_WIDTH = 8
);
   logic [SYM_WIDTH-1:0]           in;
   logic                           in_last;
   logic                           in_vld;
   logic                           in_rdy;
   logic [SYM_WIDTH-1:0]           out;
   logic                           out_last;
   logic                           out_vld;
   logic                           out_rdy;
   logic [1:0]                     read_type;
   logic [CNT_WIDTH+SYM_WIDTH-1:0] read_query;
   logic [CNT_WIDTH+SYM_WIDTH-1:0] read_result;
   logic                           read_rdy;
   logic                           err;

   modport master (
      input  in, in_last, in_vld, out_rdy, read_result, read_rdy,
      output in_rdy, out, out_last, out_vld, read_type, read_query, err
   );
   modport slave (
      output in, in_last, in_vld, out_rdy, read_result, read_rdy,
      input  in_rdy, out, out_last, out_vld, read_type, read_query, err
   );
endinterface

// File: rtl/ans_encoder.sv
// Streaming rANS encoder: per symbol fetch PMF/CMF, renormalise nibbles out, update state;
// on the last symbol flush the state MSB nibble first (a downstream LIFO reverses the stream).
module ans_encoder #(
   parameter int SYM_WIDTH   = 4,
   parameter int CNT_WIDTH   = 8,
   parameter int STATE_WIDTH = 16,
   parameter int SYM_COUNT   = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          ena,
   ans_encoder_if.master bus
);
   localparam int QW  = CNT_WIDTH + SYM_WIDTH;
   localparam int NIB = STATE_WIDTH / SYM_WIDTH;
   localparam int CW  = $clog2(NIB + 1);

   // Table request codes; ICMF (3) exists on the port but the encoder never issues it.
   localparam logic [1:0] RT_NONE = 2'd0;
   localparam logic [1:0] RT_PMF  = 2'd1;
   localparam logic [1:0] RT_CMF  = 2'd2;

   typedef enum logic [2:0] {
      S_INIT, S_IDLE, S_GET_F, S_GET_C, S_RENORM, S_ENCODE, S_FLUSH
   } state_t;

   state_t                 state_q, state_d;
   logic [STATE_WIDTH-1:0] x_q, x_d, m_q, m_d, f_q, f_d, c_q, c_d;
   logic [SYM_WIDTH-1:0]   s_q, s_d, out_q, out_d;
   logic                   last_q, last_d, out_last_q, out_last_d;
   logic                   out_vld_q, out_vld_d, err_q, err_d;
   logic [1:0]             rt_q, rt_d;
   logic [QW-1:0]          rq_q, rq_d;
   logic [CW-1:0]          cnt_q, cnt_d;

   logic [STATE_WIDTH-1:0] res, f_div, x_enc;
   logic                   renorm_need;

   assign res         = STATE_WIDTH'(bus.read_result);
   // f is never zero in ENCODE; the guard only keeps the divider well defined.
   assign f_div       = (f_q == '0) ? STATE_WIDTH'(1) : f_q;
   assign x_enc       = (x_q / f_div) * m_q + (x_q % f_div) + c_q;
   assign renorm_need = {SYM_WIDTH'(0), x_q} >= {f_q, SYM_WIDTH'(0)};

   always_comb begin
      state_d    = state_q;
      x_d        = x_q;
      m_d        = m_q;
      f_d        = f_q;
      c_d        = c_q;
      s_d        = s_q;
      last_d     = last_q;
      out_d      = out_q;
      out_last_d = out_last_q;
      out_vld_d  = out_vld_q;
      err_d      = err_q;
      rt_d       = rt_q;
      rq_d       = rq_q;
      cnt_d      = cnt_q;
      case (state_q)
         S_INIT: begin
            if (rt_q == RT_NONE) begin
               rt_d = RT_CMF;
               rq_d = QW'(SYM_COUNT - 1);
            end else if (bus.read_rdy) begin
               rt_d    = RT_NONE;
               m_d     = res;
               x_d     = res;
               state_d = S_IDLE;
            end
         end
         S_IDLE: begin
            if (bus.in_vld) begin
               s_d     = bus.in;
               last_d  = bus.in_last;
               state_d = S_GET_F;
            end
         end
         S_GET_F: begin
            if (rt_q == RT_NONE) begin
               rt_d = RT_PMF;
               rq_d = QW'(s_q);
            end else if (bus.read_rdy) begin
               rt_d = RT_NONE;
               f_d  = res;
               if (res == '0) begin
                  err_d   = 1'b1;
                  state_d = last_q ? S_FLUSH : S_IDLE;
               end else if (s_q == '0) begin
                  c_d     = '0;
                  state_d = S_RENORM;
               end else begin
                  state_d = S_GET_C;
               end
            end
         end
         S_GET_C: begin
            if (rt_q == RT_NONE) begin
               rt_d = RT_CMF;
               rq_d = QW'(s_q) - QW'(1);
            end else if (bus.read_rdy) begin
               rt_d    = RT_NONE;
               c_d     = res;
               state_d = S_RENORM;
            end
         end
         S_RENORM: begin
            // Present a nibble, then shift x only once it has actually been taken.
            if (out_vld_q) begin
               if (bus.out_rdy) begin
                  out_vld_d = 1'b0;
                  x_d       = x_q >> SYM_WIDTH;
               end
            end else if (renorm_need) begin
               out_d     = x_q[SYM_WIDTH-1:0];
               out_vld_d = 1'b1;
            end else begin
               state_d = S_ENCODE;
            end
         end
         S_ENCODE: begin
            x_d     = x_enc;
            state_d = last_q ? S_FLUSH : S_IDLE;
         end
         S_FLUSH: begin
            // x is shifted left per nibble so the top nibble is always the next one out.
            if (out_vld_q) begin
               if (bus.out_rdy) begin
                  out_vld_d  = 1'b0;
                  out_last_d = 1'b0;
                  x_d        = x_q << SYM_WIDTH;
                  if (cnt_q == CW'(NIB - 1)) begin
                     cnt_d   = '0;
                     x_d     = m_q;
                     state_d = S_IDLE;
                  end else begin
                     cnt_d = cnt_q + CW'(1);
                  end
               end
            end else begin
               out_d      = x_q[STATE_WIDTH-1 -: SYM_WIDTH];
               out_last_d = (cnt_q == CW'(NIB - 1));
               out_vld_d  = 1'b1;
            end
         end
         default: state_d = S_INIT;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_INIT;
         x_q        <= '0;
         m_q        <= '0;
         f_q        <= '0;
         c_q        <= '0;
         s_q        <= '0;
         last_q     <= 1'b0;
         out_q      <= '0;
         out_last_q <= 1'b0;
         out_vld_q  <= 1'b0;
         err_q      <= 1'b0;
         rt_q       <= RT_NONE;
         rq_q       <= '0;
         cnt_q      <= '0;
      end else if (ena) begin
         state_q    <= state_d;
         x_q        <= x_d;
         m_q        <= m_d;
         f_q        <= f_d;
         c_q        <= c_d;
         s_q        <= s_d;
         last_q     <= last_d;
         out_q      <= out_d;
         out_last_q <= out_last_d;
         out_vld_q  <= out_vld_d;
         err_q      <= err_d;
         rt_q       <= rt_d;
         rq_q       <= rq_d;
         cnt_q      <= cnt_d;
      end
   end

   assign bus.in_rdy     = (state_q == S_IDLE);
   assign bus.out        = out_q;
   assign bus.out_last   = out_last_q;
   assign bus.out_vld    = out_vld_q;
   assign bus.read_type  = rt_q;
   assign bus.read_query = rq_q;
   assign bus.err        = err_q;
endmodule

// File: tb/tb_ans_encoder.sv
// Bench for ans_encoder: fixed vectors, stall/reset sequences, random messages vs. an arithmetic rANS model.
module tb_ans_encoder;
   localparam int SW = 4, CNTW = 8, STW = 16, SC = 16, M = 16;

   logic clk = 1'b0;
   logic rst_n;
   logic ena;
   always #5 clk = ~clk;

   ans_encoder_if #(.SYM_WIDTH(SW), .CNT_WIDTH(CNTW)) bus ();
   ans_encoder #(.SYM_WIDTH(SW), .CNT_WIDTH(CNTW), .STATE_WIDTH(STW), .SYM_COUNT(SC))
      dut (.clk(clk), .rst_n(rst_n), .ena(ena), .bus(bus.master));

   int pmf [SC];
   int cum [SC+1];              // cum[s] = sum of pmf below s
   int nvec = 0, nbad = 0;

   int  sym_q [$];              // sym | last<<8
   int  got_q [$];              // nibble | last<<4
   int  exp_q [$];
   int  msg   [$];
   bit  in_fire = 0, rnd_ena = 0, rnd_rdy = 0, hold_rdy = 0, stall_req = 0;
   int  stall_left = 0, stall_snap = 0, rd_delay = 0, cmf15_cnt = 0, bad_query = 0;
   bit  err_exp = 0;

   typedef struct {
      int          n;
      int          s [4];
      int          en;
      logic [31:0] exp;
      bit          err;
   } vec_t;
   vec_t tv [5];

   task automatic check(input string name, input int got, input int exp);
      nvec++;
      if (got !== exp) begin
         nbad++;
         $display("FAIL %s: got %0d, required %0d", name, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      #2;
   endtask

   // Environment: source, sink, table responder; all act on the falling edge.
   always @(negedge clk) begin
      if (!rst_n) begin
         bus.in_vld = 1'b0;
         in_fire    = 1'b0;
      end
      if (in_fire) begin
         if (sym_q.size() > 0) void'(sym_q.pop_front());
         bus.in_vld = 1'b0;
         in_fire    = 1'b0;
      end
      ena = rnd_ena ? ($urandom_range(0, 4) != 0) : 1'b1;
      if (hold_rdy) bus.out_rdy = 1'b0;
      else if (stall_left > 0) begin
         check("stall_hold", int'({bus.out_vld, bus.out_last, bus.out}), stall_snap);
         stall_left--;
         bus.out_rdy = 1'b0;
      end else if (stall_req && bus.out_vld) begin
         stall_req   = 1'b0;
         stall_left  = 4;
         stall_snap  = int'({bus.out_vld, bus.out_last, bus.out});
         bus.out_rdy = 1'b0;
      end else bus.out_rdy = rnd_rdy ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (rst_n && sym_q.size() > 0 && !bus.in_vld) begin
         int v;
         v = sym_q[0];
         bus.in_vld  = 1'b1;
         bus.in      = SW'(v);
         bus.in_last = (v >= 256);
      end
      if (bus.in_vld && bus.in_rdy && ena) in_fire = 1'b1;
      if (rst_n && bus.out_vld && bus.out_rdy && ena)
         got_q.push_back(int'({bus.out_last, bus.out}));
      if (bus.read_type == 2'd0) begin
         bus.read_rdy = 1'b0;
         rd_delay     = $urandom_range(0, 3);
      end else if (!bus.read_rdy) begin
         if (rd_delay == 0) begin
            int q;
            q = int'(bus.read_query);
            bus.read_rdy = 1'b1;
            if (bus.read_type == 2'd1) bus.read_result = (q < SC) ? 12'(pmf[q]) : 12'd0;
            else if (bus.read_type == 2'd2) bus.read_result = (q < SC) ? 12'(cum[q+1]) : 12'd0;
            else begin
               bad_query++;
               bus.read_result = 12'd0;
            end
            if (bus.read_type == 2'd2 && q == SC - 1) cmf15_cnt++;
         end else rd_delay--;
      end
   end

   // Reference: plain rANS arithmetic over the whole message.
   task automatic model_msg();
      int x, f, c, s;
      exp_q.delete();
      x = M;
      foreach (msg[i]) begin
         s = msg[i];
         f = pmf[s];
         if (f == 0) err_exp = 1'b1;
         else begin
            c = cum[s];
            while (x >= 16 * f) begin
               exp_q.push_back(x % 16);
               x = x / 16;
            end
            x = (x / f) * M + (x % f) + c;
         end
      end
      for (int k = 3; k >= 0; k--)
         exp_q.push_back(((x >> (4 * k)) & 15) | ((k == 0) ? 16 : 0));
   endtask

   // Round trip: reverse the captured stream and decode it back to the message.
   task automatic check_decode(input string tag);
      int r [$];
      int v [$];
      int x, p, slot, s, ok;
      ok = 1;
      foreach (got_q[i]) r.push_front(got_q[i] & 15);
      foreach (msg[i]) if (pmf[msg[i]] != 0) v.push_back(msg[i]);
      if (r.size() < 4) ok = 0;
      else begin
         x = r[0] | (r[1] << 4) | (r[2] << 8) | (r[3] << 12);
         p = 4;
         for (int j = v.size() - 1; j >= 0; j--) begin
            slot = x % M;
            s = 0;
            for (int t = 0; t < SC; t++) if (cum[t] <= slot && slot < cum[t+1]) s = t;
            if (s != v[j]) ok = 0;
            x = pmf[s] * (x / M) + slot - cum[s];
            while (x < M && p < r.size()) begin
               x = (x << 4) | r[p];
               p++;
            end
         end
         if (x != M || p != r.size()) ok = 0;
      end
      check({tag, "_decode"}, ok, 1);
   endtask

   task automatic send_msg();
      foreach (msg[i]) sym_q.push_back(msg[i] | ((i == msg.size() - 1) ? 256 : 0));
   endtask

   task automatic wait_msg(input int n);
      int t;
      t = 0;
      while (!(got_q.size() >= n && sym_q.size() == 0 && !bus.in_vld && bus.in_rdy) && t < 4000) begin
         tick();
         t++;
      end
      check("msg_done_in_time", int'(t < 4000), 1);
      repeat (4) tick();
   endtask

   task automatic cmp_stream(input string tag);
      check({tag, "_len"}, got_q.size(), exp_q.size());
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
         check({tag, "_nibble"}, got_q[i], exp_q[i]);
      check({tag, "_err"}, int'(bus.err), int'(err_exp));
      check_decode(tag);
      got_q.delete();
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_in_rdy"}, int'(bus.in_rdy), 0);
      check({tag, "_out_vld"}, int'(bus.out_vld), 0);
      check({tag, "_out_last"}, int'(bus.out_last), 0);
      check({tag, "_out"}, int'(bus.out), 0);
      check({tag, "_err"}, int'(bus.err), 0);
      check({tag, "_read_type"}, int'(bus.read_type), 0);
      check({tag, "_read_query"}, int'(bus.read_query), 0);
   endtask

   task automatic wait_ready(input string tag);
      int t;
      t = 0;
      while (!bus.in_rdy && t < 200) begin
         if (bus.out_vld) check({tag, "_early_out_vld"}, int'(bus.out_vld), 0);
         tick();
         t++;
      end
      check({tag, "_ready_in_time"}, int'(t < 200), 1);
   endtask

   initial begin
      int base, nsym, v;
      foreach (pmf[i]) pmf[i] = 0;
      pmf[0] = 8; pmf[1] = 4; pmf[2] = 2; pmf[3] = 2;
      cum[0] = 0;
      for (int i = 0; i < SC; i++) cum[i+1] = cum[i] + pmf[i];

      tv[0] = '{n: 2, s: '{0, 1, 0, 0}, en: 4, exp: 32'h0088,   err: 1'b0};
      tv[1] = '{n: 3, s: '{0, 1, 2, 0}, en: 5, exp: 32'h8004C,  err: 1'b0};
      tv[2] = '{n: 1, s: '{3, 0, 0, 0}, en: 4, exp: 32'h008E,   err: 1'b0};
      tv[3] = '{n: 3, s: '{2, 2, 2, 0}, en: 6, exp: 32'hCC002C, err: 1'b0};
      tv[4] = '{n: 2, s: '{5, 0, 0, 0}, en: 4, exp: 32'h0020,   err: 1'b1};

      bus.in = '0; bus.in_last = 1'b0; bus.in_vld = 1'b0; bus.out_rdy = 1'b1;
      bus.read_result = '0; bus.read_rdy = 1'b0; ena = 1'b1;
      rst_n = 1'b0;
      repeat (3) tick();
      check_reset_outputs("reset");
      rst_n = 1'b1;
      wait_ready("init");
      check("init_cmf_queries", cmf15_cnt, 1);

      for (int k = 0; k < 5; k++) begin
         msg.delete();
         for (int i = 0; i < tv[k].n; i++) msg.push_back(tv[k].s[i]);
         exp_q.delete();
         for (int i = 0; i < tv[k].en; i++)
            exp_q.push_back(int'((tv[k].exp >> (4 * (tv[k].en - 1 - i))) & 32'hF) |
                            ((i == tv[k].en - 1) ? 16 : 0));
         err_exp = err_exp | tv[k].err;
         send_msg();
         wait_msg(tv[k].en);
         cmp_stream($sformatf("vec%0d", k));
      end

      // Sink stalls for five cycles on the first flush nibble.
      msg.delete(); msg.push_back(0); msg.push_back(1);
      model_msg();
      stall_req = 1'b1;
      send_msg();
      wait_msg(exp_q.size());
      check("stall_consumed", int'(stall_req), 0);
      cmp_stream("stall");

      // Reset while RENORM waits on a held-off sink.
      msg.delete(); msg.push_back(2); msg.push_back(2); msg.push_back(2);
      hold_rdy = 1'b1;
      send_msg();
      begin
         int t;
         t = 0;
         while (!bus.out_vld && t < 200) begin tick(); t++; end
         check("renorm_out_vld_seen", int'(bus.out_vld), 1);
      end
      base = cmf15_cnt;
      rst_n = 1'b0;
      sym_q.delete();
      tick();
      check_reset_outputs("midreset");
      got_q.delete();
      hold_rdy = 1'b0;
      err_exp  = 1'b0;
      rst_n    = 1'b1;
      wait_ready("reinit");
      check("reinit_cmf_queries", cmf15_cnt - base, 1);
      msg.delete(); msg.push_back(0); msg.push_back(1);
      model_msg();
      send_msg();
      wait_msg(exp_q.size());
      cmp_stream("after_reset");

      // Random messages with clock-enable gaps and sink backpressure.
      rnd_ena = 1'b1;
      rnd_rdy = 1'b1;
      for (int k = 0; k < 25; k++) begin
         msg.delete();
         nsym = $urandom_range(1, 6);
         for (int i = 0; i < nsym; i++) begin
            v = $urandom_range(0, 9);
            msg.push_back((v == 9) ? 5 : (v % 4));
         end
         model_msg();
         send_msg();
         wait_msg(exp_q.size());
         cmp_stream($sformatf("rnd%0d", k));
      end
      check("no_icmf_queries", bad_query, 0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
      $finish;
   end
endmodule
